// File: rtl/rf_wb_queue_pkg.sv
// rf_wb_queue shared definitions.
// Default geometry for the writeback queue and its entry layout.
package rf_wb_queue_pkg;

  localparam int WB_DEPTH = 4;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_EW    = WB_AW + WB_DW;

endpackage

// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue bus bundle.
// Producer ports, register file write port and forwarding lookups.
interface rf_wb_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_wd;
  logic          md_valid;
  logic          md_ready;
  logic [AW-1:0] md_rd;
  logic [DW-1:0] md_wd;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic          RFWr;
  logic [AW-1:0] q1_addr;
  logic [AW-1:0] q2_addr;
  logic          q1_hit;
  logic          q2_hit;
  logic [DW-1:0] q1_data;
  logic [DW-1:0] q2_data;
  logic          empty;

  modport slave (
    input  alu_valid, alu_rd, alu_wd,
    input  md_valid, md_rd, md_wd,
    input  q1_addr, q2_addr,
    output alu_ready, md_ready,
    output A3, WD, RFWr,
    output q1_hit, q2_hit, q1_data, q2_data,
    output empty
  );

  modport master (
    output alu_valid, alu_rd, alu_wd,
    output md_valid, md_rd, md_wd,
    output q1_addr, q2_addr,
    input  alu_ready, md_ready,
    input  A3, WD, RFWr,
    input  q1_hit, q2_hit, q1_data, q2_data,
    input  empty
  );

endinterface

// File: rtl/rf_wb_queue_fifo.sv
// Dual-push single-pop circular buffer.
// Storage and valid mask are exposed for forwarding scans.
module rf_wb_queue_fifo #(
  parameter  int DEPTH = 4,
  parameter  int EW    = 37,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr0_en,
  input  logic [EW-1:0] wr0_data,
  input  logic          wr1_en,
  input  logic [EW-1:0] wr1_data,
  output logic [EW-1:0] mem [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [PW-1:0] wptr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic [EW-1:0] head
);

  logic [PW-1:0] rptr;
  logic [CW-1:0] n_push;
  logic          pop;

  assign empty  = (count == '0);
  assign pop    = !empty;
  assign n_push = CW'(wr0_en) + CW'(wr1_en);
  assign head   = mem[rptr];

  // pointer and occupancy update; head always retires when present
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + PW'(pop);
      wptr  <= wptr + PW'(n_push);
      count <= count + n_push - CW'(pop);
    end
  end

  // storage writes; stale slots are hidden by the valid mask
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr] <= wr0_data;
    if (wr1_en) mem[wptr + PW'(1)] <= wr1_data;
  end

  // slot is live when its distance from rptr is below count
  always_comb begin
    logic [PW-1:0] age;
    age   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - rptr;
      valid[i] = ({1'b0, age} < count);
    end
  end

endmodule

// File: rtl/rf_wb_queue.sv
// Writeback queue in front of the register file write port.
// Merges ALU and mul/div results in order and forwards queued data.
module rf_wb_queue
  import rf_wb_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input logic          clk,
  input logic          rst,
  rf_wb_queue_if.slave bus
);

  localparam int EW = AW + DW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [EW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic             empty;
  logic [EW-1:0]    head;
  logic             alu_push;
  logic             md_push;
  logic             wr0_en;
  logic             wr1_en;
  logic [EW-1:0]    wr0_data;
  logic [EW-1:0]    wr1_data;
  logic [AW-1:0]    qa [2];
  logic             qh [2];
  logic [DW-1:0]    qd [2];

  // the head retiring this cycle frees its slot for a new push
  assign free = CW'(DEPTH) - count + CW'(!empty);

  assign bus.alu_ready = (free >= CW'(1));
  assign bus.md_ready  = (free >= CW'(2));

  // r0 results complete the handshake but are dropped
  assign alu_push = bus.alu_valid && bus.alu_ready
                 && (bus.alu_rd != '0);
  assign md_push  = bus.md_valid && bus.md_ready
                 && (bus.md_rd != '0);

  // ALU goes first; mul/div takes the second slot when both push
  always_comb begin
    wr0_en   = alu_push || md_push;
    wr1_en   = alu_push && md_push;
    wr0_data = alu_push ? {bus.alu_rd, bus.alu_wd}
                        : {bus.md_rd, bus.md_wd};
    wr1_data = {bus.md_rd, bus.md_wd};
  end

  rf_wb_queue_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_data (wr1_data),
    .mem      (mem),
    .valid    (valid),
    .wptr     (wptr),
    .count    (count),
    .empty    (empty),
    .head     (head)
  );

  assign bus.RFWr  = !empty;
  assign bus.A3    = empty ? '0 : head[EW-1:DW];
  assign bus.WD    = empty ? '0 : head[DW-1:0];
  assign bus.empty = empty;

  assign qa[0] = bus.q1_addr;
  assign qa[1] = bus.q2_addr;

  for (genvar p = 0; p < 2; p++) begin : g_scan
    logic          hit;
    logic [DW-1:0] data;

    // walk oldest to youngest so the youngest match wins
    always_comb begin
      logic [PW-1:0] idx;
      idx  = '0;
      hit  = 1'b0;
      data = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        idx = wptr - PW'(k) - PW'(1);
        if (valid[idx] && (qa[p] != '0)
            && (mem[idx][EW-1:DW] == qa[p])) begin
          hit  = 1'b1;
          data = mem[idx][DW-1:0];
        end
      end
    end

    assign qh[p] = hit;
    assign qd[p] = data;
  end

  assign bus.q1_hit  = qh[0];
  assign bus.q2_hit  = qh[1];
  assign bus.q1_data = qd[0];
  assign bus.q2_data = qd[1];

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue.
// Scoreboard of expected retirements with a separate write monitor.
module tb_rf_wb_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  ent_t sb [$];

  rf_wb_queue_if #(.AW(5), .DW(32)) bus ();

  rf_wb_queue #(
    .DEPTH (DEPTH),
    .AW    (5),
    .DW    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void fwd(input logic [4:0] a,
                              output logic h,
                              output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].rd == a) begin
          h = 1'b1;
          d = sb[i].wd;
          break;
        end
      end
    end
  endfunction

  // monitor: every register file write must match the oldest expected
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (bus.RFWr === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: A3=%0d WD=%h",
                   bus.A3, bus.WD);
        end else begin
          e = sb.pop_front();
          chk("A3", {27'd0, bus.A3}, {27'd0, e.rd});
          chk("WD", bus.WD, e.wd);
        end
      end
    end
  end

  // one clock of stimulus; entered and left at posedge+1
  task automatic cyc(input logic r,
                     input logic av, input logic [4:0] ard,
                     input logic [31:0] awd,
                     input logic mv, input logic [4:0] mrd,
                     input logic [31:0] mwd,
                     input logic [4:0] a1, input logic [4:0] a2);
    int n;
    int free;
    logic h;
    logic [31:0] d;
    rst           = r;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_wd    = awd;
    bus.md_valid  = mv;
    bus.md_rd     = mrd;
    bus.md_wd     = mwd;
    bus.q1_addr   = a1;
    bus.q2_addr   = a2;
    #2;
    n    = sb.size();
    free = DEPTH - n + ((n != 0) ? 1 : 0);
    chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, free >= 1});
    chk("md_ready", {31'd0, bus.md_ready}, {31'd0, free >= 2});
    chk("empty", {31'd0, bus.empty}, {31'd0, n == 0});
    chk("RFWr", {31'd0, bus.RFWr}, {31'd0, n != 0});
    if (n == 0) begin
      chk("A3_idle", {27'd0, bus.A3}, 32'd0);
      chk("WD_idle", bus.WD, 32'd0);
    end
    fwd(a1, h, d);
    chk("q1_hit", {31'd0, bus.q1_hit}, {31'd0, h});
    chk("q1_data", bus.q1_data, d);
    fwd(a2, h, d);
    chk("q2_hit", {31'd0, bus.q2_hit}, {31'd0, h});
    chk("q2_data", bus.q2_data, d);
    @(negedge clk);
    #2;
    if (r) begin
      sb.delete();
    end else begin
      if (av && free >= 1 && ard != 0) sb.push_back('{ard, awd});
      if (mv && free >= 2 && mrd != 0) sb.push_back('{mrd, mwd});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a1, a2);
  endtask

  initial begin
    logic av, mv;
    logic [4:0] ard, mrd, a1, a2;
    int guard;
    rst           = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_wd    = '0;
    bus.md_valid  = 1'b0;
    bus.md_rd     = '0;
    bus.md_wd     = '0;
    bus.q1_addr   = '0;
    bus.q2_addr   = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // single push and its one-cycle latency
    cyc(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd6);
    idle(5'd5, 5'd0);

    // dual push, mul/div is younger
    cyc(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd0);
    idle(5'd3, 5'd3);
    idle(5'd3, 5'd5);
    idle(5'd3, 5'd0);

    // r0 results are swallowed
    cyc(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // fill with dual pushes, then mul/div backpressure
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 5'd7, 32'h70 + i, 1'b1, 5'd8, 32'h80 + i,
          5'd7, 5'd8);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h90 + i,
          5'd9, 5'd8);
    for (int i = 0; i < 4; i++) idle(5'd9, 5'd7);

    // mixed traffic across several pointer wraps
    for (int i = 0; i < 3 * DEPTH; i++) begin
      av  = 1'($urandom_range(0, 1));
      mv  = 1'($urandom_range(0, 1));
      ard = 5'($urandom_range(1, 4));
      mrd = 5'($urandom_range(1, 4));
      a1  = 5'($urandom_range(0, 4));
      a2  = 5'($urandom_range(1, 4));
      cyc(1'b0, av, ard, 32'h1000 + i, mv, mrd, 32'h2000 + i,
          a1, a2);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(5'd1, 5'd2);

    // reset with three entries queued and both ports offering
    cyc(1'b0, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 5'd10, 5'd11);
    cyc(1'b0, 1'b1, 5'd12, 32'hA1, 1'b1, 5'd13, 32'hB1, 5'd12, 5'd13);
    cyc(1'b1, 1'b1, 5'd14, 32'hA2, 1'b1, 5'd15, 32'hB2, 5'd11, 5'd13);
    idle(5'd12, 5'd14);
    idle(5'd13, 5'd15);
    idle(5'd11, 5'd10);

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      idle(5'd0, 5'd0);
      guard++;
    end
    chk("drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
